// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared definitions for the LCD bus arbiter.
// Holds the FSM state encoding, requester index constants, long-command
// codes and small helpers used by the arbiter and its sub-module.
package lcd_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    localparam logic [1:0] REQ_CLK = 2'd0;
    localparam logic [1:0] REQ_ALM = 2'd1;
    localparam logic [1:0] REQ_TMR = 2'd2;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int unsigned WORD_W = 9;

    // Clear and home are the only commands needing the long settle time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
        return !rs && ((db == CMD_CLEAR) || (db == CMD_HOME));
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        if (oh[REQ_ALM])
            return REQ_ALM;
        else if (oh[REQ_TMR])
            return REQ_TMR;
        else
            return REQ_CLK;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester/LCD bus bundle for the LCD bus arbiter.
//   req   : per-requester write request (0 clock, 1 alarm, 2 timer)
//   wdata : packed {rs2,db2, rs1,db1, rs0,db0}, 9 bits per requester
//   gnt   : one-hot word-accepted pulse
//   done  : one-hot transfer-complete pulse
//   busy  : high from grant cycle through done cycle
//   E/RS/RW/DB : LCD strobe, register select, read/write, data bus
// master = requester side, slave = arbiter side.
interface lcd_bus_arbiter_if;
    import lcd_bus_arbiter_pkg::*;

    logic [2:0]          req;
    logic [3*WORD_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          done;
    logic                busy;
    logic                E;
    logic                RS;
    logic                RW;
    logic [7:0]          DB;

    modport master (
        output req, wdata,
        input  gnt, done, busy, E, RS, RW, DB
    );

    modport slave (
        input  req, wdata,
        output gnt, done, busy, E, RS, RW, DB
    );

endinterface

// File: rtl/lcd_bus_arbiter_rr_arbiter3.sv
// Three-way round-robin selector.
//   req   : request vector
//   last  : index of the previous winner; search starts just after it
//   grant : one-hot winner (all zero when nothing is requested)
module rr_arbiter3
    import lcd_bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        case (last)
            REQ_CLK: begin
                if      (req[REQ_ALM]) grant[REQ_ALM] = 1'b1;
                else if (req[REQ_TMR]) grant[REQ_TMR] = 1'b1;
                else if (req[REQ_CLK]) grant[REQ_CLK] = 1'b1;
            end
            REQ_ALM: begin
                if      (req[REQ_TMR]) grant[REQ_TMR] = 1'b1;
                else if (req[REQ_CLK]) grant[REQ_CLK] = 1'b1;
                else if (req[REQ_ALM]) grant[REQ_ALM] = 1'b1;
            end
            default: begin
                if      (req[REQ_CLK]) grant[REQ_CLK] = 1'b1;
                else if (req[REQ_ALM]) grant[REQ_ALM] = 1'b1;
                else if (req[REQ_TMR]) grant[REQ_TMR] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780-style LCD write port among three requesters.
// Each accepted word runs SETUP -> PULSE (E high) -> HOLD -> WAIT, with a
// long settle after clear/home, then reports done to its owner.
//   mclk : system clock (rising edge)
//   rst  : asynchronous active-low reset, release synchronised to mclk
//   bus  : requester/LCD bundle (slave side)
module lcd_bus_arbiter
    import lcd_bus_arbiter_pkg::*;
#(
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_PULSE      = 10,
    parameter int unsigned T_HOLD       = 10,
    parameter int unsigned T_WAIT_SHORT = 400,
    parameter int unsigned T_WAIT_LONG  = 16000
) (
    input  logic               mclk,
    input  logic               rst,
    lcd_bus_arbiter_if.slave   bus
);

    localparam int unsigned MAX_T = max_u(max_u(max_u(T_SETUP, T_PULSE), max_u(T_HOLD, T_WAIT_SHORT)), T_WAIT_LONG);
    localparam int unsigned CW    = $clog2(MAX_T + 1);

    logic              rst_sync;
    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [1:0]        last;
    logic [2:0]        owner;
    logic [2:0]        gnt_q;
    logic [2:0]        done_q;
    logic              e_q;
    logic              rs_q;
    logic [7:0]        db_q;
    logic [2:0]        grant_rr;
    logic [1:0]        win_idx;
    logic [WORD_W-1:0] win_word;

    // Assertion reaches all state at once; release waits one mclk edge so
    // the first grant can be no earlier than the second edge after release.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst)
            rst_sync <= 1'b0;
        else
            rst_sync <= 1'b1;
    end

    rr_arbiter3 u_rr (
        .req   (bus.req),
        .last  (last),
        .grant (grant_rr)
    );

    assign win_idx = onehot_to_idx(grant_rr);

    always_comb begin
        case (win_idx)
            REQ_ALM: win_word = bus.wdata[2*WORD_W-1:WORD_W];
            REQ_TMR: win_word = bus.wdata[3*WORD_W-1:2*WORD_W];
            default: win_word = bus.wdata[WORD_W-1:0];
        endcase
    end

    always_ff @(posedge mclk or negedge rst_sync) begin
        if (!rst_sync) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            last   <= REQ_TMR;
            owner  <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            db_q   <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q <= grant_rr;
                        owner <= grant_rr;
                        last  <= win_idx;
                        rs_q  <= win_word[8];
                        db_q  <= win_word[7:0];
                        cnt   <= CW'(T_SETUP - 1);
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        e_q   <= 1'b1;
                        cnt   <= CW'(T_PULSE - 1);
                        state <= ST_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        e_q   <= 1'b0;
                        cnt   <= CW'(T_HOLD - 1);
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_long_cmd(rs_q, db_q) ? CW'(T_WAIT_LONG - 1)
                                                         : CW'(T_WAIT_SHORT - 1);
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        done_q <= owner;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // done is registered, so it shows in the first IDLE cycle; busy covers it.
    assign bus.busy = (state != ST_IDLE) || (|done_q);
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.E    = e_q;
    assign bus.RS   = rs_q;
    assign bus.RW   = 1'b0;
    assign bus.DB   = db_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter with T_SETUP/T_PULSE/T_HOLD/
// T_WAIT_SHORT/T_WAIT_LONG = 1/2/1/3/8. Stimulus pushes expected grant and
// done events; a negedge monitor pops and compares them as they appear.
module tb_lcd_bus_arbiter;

    localparam int TS = 1;
    localparam int TP = 2;
    localparam int TH = 1;
    localparam int TW = 3;
    localparam int TL = 8;

    typedef struct {
        bit         is_done;
        logic [2:0] who;
        int         span;
        logic       rs;
        logic [7:0] db;
    } exp_t;

    logic        mclk;
    logic        rst;
    logic [2:0]  req_v;
    logic [26:0] wdata_v;
    bit          auto_drop;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    lcd_bus_arbiter_if bus();

    assign bus.req   = req_v;
    assign bus.wdata = wdata_v;

    lcd_bus_arbiter #(
        .T_SETUP      (TS),
        .T_PULSE      (TP),
        .T_HOLD       (TH),
        .T_WAIT_SHORT (TW),
        .T_WAIT_LONG  (TL)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (ok)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endfunction

    function automatic void push_gnt(input logic [2:0] who, input logic [8:0] word);
        exp_t e;
        e.is_done = 1'b0;
        e.who     = who;
        e.span    = 0;
        e.rs      = word[8];
        e.db      = word[7:0];
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input logic [2:0] who, input int span);
        exp_t e;
        e.is_done = 1'b1;
        e.who     = who;
        e.span    = span;
        e.rs      = 1'b0;
        e.db      = '0;
        exp_q.push_back(e);
    endfunction

    // Monitor
    bit         active = 1'b0;
    int         gnt_cyc, e_cnt, busy_cnt;
    logic       rs_g;
    logic [7:0] db_g;
    exp_t       cur;

    always @(negedge mclk) begin
        cyc++;
        if (!rst) begin
            active = 1'b0;
        end else begin
            if (bus.RW !== 1'b0)
                check(1'b0, "rw_low", 32'(bus.RW), 0);
            if (!active && bus.E !== 1'b0)
                check(1'b0, "e_idle", 32'(bus.E), 0);
            if (bus.gnt != 3'b000) begin
                if (active)
                    check(1'b0, "gnt_while_busy", 32'(bus.gnt), 0);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_gnt", 32'(bus.gnt), 0);
                end else begin
                    cur = exp_q.pop_front();
                    check(!cur.is_done && bus.gnt == cur.who, "gnt_who", 32'(bus.gnt), 32'(cur.who));
                    check({bus.RS, bus.DB} == {cur.rs, cur.db}, "gnt_word",
                          32'({bus.RS, bus.DB}), 32'({cur.rs, cur.db}));
                    check(bus.busy === 1'b1, "busy_at_gnt", 32'(bus.busy), 1);
                    active   = 1'b1;
                    gnt_cyc  = cyc;
                    e_cnt    = 0;
                    busy_cnt = 0;
                    rs_g     = cur.rs;
                    db_g     = cur.db;
                end
            end
            if (active) begin
                busy_cnt += int'(bus.busy);
                e_cnt    += int'(bus.E);
                if ((cyc - gnt_cyc) <= TS + TP + TH - 1 && {bus.RS, bus.DB} !== {rs_g, db_g})
                    check(1'b0, "word_stable", 32'({bus.RS, bus.DB}), 32'({rs_g, db_g}));
            end
            if (bus.done != 3'b000) begin
                if (!active) begin
                    check(1'b0, "done_without_gnt", 32'(bus.done), 0);
                end else if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 32'(bus.done), 0);
                end else begin
                    cur = exp_q.pop_front();
                    check(cur.is_done && bus.done == cur.who, "done_who", 32'(bus.done), 32'(cur.who));
                    check((cyc - gnt_cyc) == cur.span, "gnt_to_done", 32'(cyc - gnt_cyc), 32'(cur.span));
                    check(e_cnt == TP, "e_width", 32'(e_cnt), 32'(TP));
                    check(busy_cnt == cur.span + 1, "busy_len", 32'(busy_cnt), 32'(cur.span + 1));
                    active = 1'b0;
                end
            end
        end
    end

    // Stimulus helpers; a requester drops its req on seeing its gnt.
    task automatic step();
        @(negedge mclk);
        if (auto_drop)
            req_v = req_v & ~bus.gnt;
    endtask

    task automatic wait_gnt(input logic [2:0] mask, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt !== mask && n < max);
        if (bus.gnt !== mask)
            check(1'b0, "timeout_gnt", 32'(bus.gnt), 32'(mask));
    endtask

    task automatic wait_done(input logic [2:0] mask, input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.done !== mask && n < max);
        if (bus.done !== mask)
            check(1'b0, "timeout_done", 32'(bus.done), 32'(mask));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        rst       = 1'b0;
        req_v     = '0;
        wdata_v   = '0;
        auto_drop = 1'b1;
        repeat (2) @(negedge mclk);

        // Reset state
        check({bus.E, bus.RS, bus.RW} === 3'b000, "rst_ctrl", 32'({bus.E, bus.RS, bus.RW}), 0);
        check(bus.DB === 8'h00, "rst_db", 32'(bus.DB), 0);
        check({bus.gnt, bus.done, bus.busy} === 7'b0, "rst_hs", 32'({bus.gnt, bus.done, bus.busy}), 0);
        rst = 1'b1;
        repeat (3) step();

        // 'A' from requester 0: short settle
        wdata_v = {9'h000, 9'h000, 9'h141};
        push_gnt(3'b001, 9'h141);
        push_done(3'b001, 7);
        req_v = 3'b001;
        wait_gnt(3'b001, 5, n);
        check(n == 1, "gnt_latency", 32'(n), 1);
        wait_done(3'b001, 20);

        // Clear command: long settle
        step();
        wdata_v[8:0] = 9'h001;
        push_gnt(3'b001, 9'h001);
        push_done(3'b001, 12);
        req_v = 3'b001;
        wait_gnt(3'b001, 5, n);
        wait_done(3'b001, 30);

        // Fresh reset, then all three held: order 0,1,2,0
        step();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        auto_drop = 1'b0;
        wdata_v = {9'h002, 9'h028, 9'h130};
        push_gnt(3'b001, 9'h130);  push_done(3'b001, 7);
        push_gnt(3'b010, 9'h028);  push_done(3'b010, 7);
        push_gnt(3'b100, 9'h002);  push_done(3'b100, 12);
        push_gnt(3'b001, 9'h130);  push_done(3'b001, 7);
        req_v = 3'b111;
        wait_done(3'b001, 20);
        wait_done(3'b010, 20);
        wait_done(3'b100, 30);
        wait_gnt(3'b001, 3, n);
        check(n == 1, "regrant_latency", 32'(n), 1);
        req_v     = 3'b000;
        auto_drop = 1'b1;
        wait_done(3'b001, 20);

        // Requester 0 re-raises at its done while 2 waits: 2 goes first
        step();
        wdata_v = {9'h14C, 9'h000, 9'h148};
        push_gnt(3'b001, 9'h148);  push_done(3'b001, 7);
        push_gnt(3'b100, 9'h14C);  push_done(3'b100, 7);
        push_gnt(3'b001, 9'h149);  push_done(3'b001, 7);
        req_v = 3'b001;
        wait_gnt(3'b001, 5, n);
        repeat (2) step();
        req_v[2] = 1'b1;
        wait_done(3'b001, 20);
        req_v[0]     = 1'b1;
        wdata_v[8:0] = 9'h149;
        wait_done(3'b100, 20);
        wait_done(3'b001, 20);

        // Reset during PULSE aborts; next request after release is normal
        step();
        wdata_v = {9'h000, 9'h155, 9'h000};
        push_gnt(3'b010, 9'h155);
        req_v = 3'b010;
        wait_gnt(3'b010, 5, n);
        k = 0;
        while (bus.E !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        check(bus.E === 1'b1, "e_rise", 32'(bus.E), 1);
        #1 rst = 1'b0;
        #1;
        check(bus.E === 1'b0, "e_async_fall", 32'(bus.E), 0);
        check({bus.gnt, bus.done, bus.busy, bus.RS, bus.DB} === 16'h0, "abort_clear",
              32'({bus.gnt, bus.done, bus.busy, bus.RS, bus.DB}), 0);
        repeat (3) step();
        push_gnt(3'b010, 9'h155);
        push_done(3'b010, 7);
        req_v = 3'b010;
        rst   = 1'b1;
        wait_gnt(3'b010, 6, n);
        check(n == 2, "release_latency", 32'(n), 2);
        wait_done(3'b010, 20);

        // One-cycle req while busy is never served
        step();
        wdata_v = {9'h000, 9'h1AA, 9'h142};
        push_gnt(3'b001, 9'h142);
        push_done(3'b001, 7);
        req_v = 3'b001;
        wait_gnt(3'b001, 5, n);
        repeat (2) step();
        req_v[1] = 1'b1;
        step();
        req_v[1] = 1'b0;
        wait_done(3'b001, 20);
        repeat (15) step();

        check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 0);
        check(bus.busy === 1'b0 && bus.gnt === 3'b000, "idle_at_end", 32'({bus.busy, bus.gnt}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter T_SETUP, default 2: cycles RS/DB are stable before E rises (>=1).
REQ-002 Parameter T_PULSE, default 10: cycles E is held high (>=1).
REQ-003 Parameter T_HOLD, default 10: cycles RS/DB are held after E falls (>=1).
REQ-004 Parameter T_WAIT_SHORT, default 400: post-write settle cycles for ordinary commands and characters (>=1).
REQ-005 Parameter T_WAIT_LONG, default 16000: post-write settle cycles for clear/home commands (>=1).
REQ-006 mclk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 req  in  3  per-requester write request; index 0 clock, 1 alarm, 2 timer.
REQ-009 wdata  in  27  packed {rs2,db2[7:0], rs1,db1[7:0], rs0,db0[7:0]}; 9 bits per requester.
REQ-010 gnt  out  3  one-hot, one-cycle pulse: that requester's word is accepted.
REQ-011 done  out  3  one-hot, one-cycle pulse: that requester's transfer, including settle, is complete.
REQ-012 busy  out  1  high from the grant cycle through the done cycle inclusive.
REQ-013 E, RS, RW  out  1 each  LCD strobe, register select, and read/write (RW is tied low).
REQ-014 DB  out  8  LCD data bus.

Function
REQ-015 FSM states are IDLE, SETUP, PULSE, HOLD and WAIT, with a single down-counter sized for T_WAIT_LONG.
REQ-016 In IDLE with any req high, the edge selects a winner, latches its rs/db into RS/DB, pulses gnt, and enters SETUP with counter = T_SETUP-1.
REQ-017 Arbitration is round-robin: search starts at (last winner+1) mod 3, and last winner after reset is 2, so requester 0 wins first.
REQ-018 SETUP lasts T_SETUP cycles with E=0, then PULSE lasts T_PULSE cycles with E=1, then HOLD lasts T_HOLD cycles with E=0.
REQ-019 RS and DB stay unchanged from the grant through the end of HOLD.
REQ-020 WAIT lasts T_WAIT_LONG cycles when the latched RS=0 and DB is 0x01 or 0x02, and T_WAIT_SHORT cycles otherwise.
REQ-021 On the last WAIT cycle, done pulses for the owner and the FSM returns to IDLE; the next grant is possible on the following edge.
REQ-022 Grant-to-done span is T_SETUP+T_PULSE+T_HOLD+WAIT cycles.
REQ-023 Requests arriving while busy are ignored until IDLE; a requester holds req until gnt.
REQ-024 A req dropped before its gnt is never served, and no state is kept for it.
REQ-025 Simultaneous requests are resolved by the round-robin rule alone; the loser is served on the next arbitration if it is still requesting.
REQ-026 A requester re-raising req at done competes normally and cannot win twice in a row while another requester is waiting.
REQ-027 RW=0 always; the block never reads the LCD busy flag.
REQ-028 The counter never wraps: each state loads the counter on entry and exits when the counter reaches 0.

Reset
REQ-029 rst low immediately forces state=IDLE, E=0, RS=0, RW=0, DB=0x00, gnt=0, done=0, busy=0, counter=0, last winner=2.
REQ-030 Reset mid-transfer aborts the transfer with no done pulse; E falls asynchronously.
REQ-031 Release of rst is synchronised to mclk, and the first grant occurs no earlier than the second rising edge after release.

Structure
REQ-032 A shared package holds the FSM state encoding, the requester index constants (REQ_CLK=0, REQ_ALM=1, REQ_TMR=2), and the long-command codes 0x01 and 0x02.
REQ-033 Round-robin selection is a separate sub-module rr_arbiter3, which takes req and last winner and produces a one-hot grant.

Verification
REQ-034 Use parameters 1/2/1/3/8 throughout; after reset, req=001 with word 0x141 ('A', RS=1) -> gnt=001 at edge 1, E high for exactly 2 cycles, done=001 exactly 7 cycles after gnt, DB=0x41 and RS=1 throughout.
REQ-035 req=001 with word 0x001 (clear) -> done=001 12 cycles after gnt, and busy high for exactly 13 cycles.
REQ-036 req=111 held continuously -> grant order 0,1,2,0, with no gnt while busy.
REQ-037 Requester 0 re-raises req at its done while requester 2 is pending -> requester 2 is granted next.
REQ-038 rst asserted during PULSE -> E=0 in the same cycle, no done, and after release req=010 is granted normally.
REQ-039 req pulsed for one cycle while busy -> never granted, and no gnt appears after IDLE.
